fifo_pkt_reader: RTL and testbench

- Read-side consumer for the team's async FIFO, running in the rclk domain.
- Drives pop and samples rdata. Parses a length-prefixed packet format: one header word holding payload length N, then N payload words.
- Presents payload on a valid/ready stream with sop/eop markers, through a 2-entry output buffer.
- Sits between the async FIFO read port and downstream packet logic.

---
 rtl/fifo_pkt_pkg.sv | 23 ++
 rtl/fifo_pkt_obuf.sv | 100 ++++++++++
 rtl/fifo_pkt_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkt_pkg.sv
`default_nettype none
// fifo_pkt_pkg: shared state encoding, buffer entry type and constants for fifo_pkt_reader (rev 1.0)
package fifo_pkt_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int OBUF_DEPTH = 2;
  localparam int PKTCNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHK     = 2'd2
  } state_t;

  typedef struct packed {
    logic [DWIDTH_DEF-1:0] data;
    logic                  sop;
    logic                  eop;
    logic                  err;
  } obuf_entry_t;

endpackage
`default_nettype wire

// File: rtl/fifo_pkt_obuf.sv
`default_nettype none
// fifo_pkt_obuf: 2-entry valid/ready output buffer, head register drives the outputs (rev 1.0)
module fifo_pkt_obuf
  import fifo_pkt_pkg::*;
(
  input  logic        rclk,
  input  logic        reset_L,
  input  logic        wr_en,
  input  obuf_entry_t wr_entry,
  input  logic        wr_pend,
  input  logic        rd_ready,
  input  logic        chk_done,
  input  logic        chk_err,
  output logic        valid,
  output obuf_entry_t head,
  output logic [1:0]  count
);

  obuf_entry_t r_head, r_tail, n_head, n_tail;
  logic        r_head_pend, r_tail_pend, n_head_pend, n_tail_pend;
  logic [1:0]  r_count, n_count;
  logic        w_rd;

  // A pending entry is an eop word still waiting for its checksum verdict.
  assign valid = (r_count != 2'd0) && !r_head_pend;
  assign head  = r_head;
  assign count = r_count;
  assign w_rd  = valid && rd_ready;

  always_comb begin
    n_head      = r_head;
    n_tail      = r_tail;
    n_head_pend = r_head_pend;
    n_tail_pend = r_tail_pend;
    n_count     = r_count;
    case ({wr_en, w_rd})
      2'b10: begin
        if (r_count == 2'd0) begin
          n_head      = wr_entry;
          n_head_pend = wr_pend;
        end else begin
          n_tail      = wr_entry;
          n_tail_pend = wr_pend;
        end
        n_count = r_count + 2'd1;
      end
      2'b01: begin
        if (r_count == 2'd2) begin
          n_head      = r_tail;
          n_head_pend = r_tail_pend;
        end else begin
          n_head      = '0;
          n_head_pend = 1'b0;
        end
        n_tail_pend = 1'b0;
        n_count     = r_count - 2'd1;
      end
      2'b11: begin
        if (r_count == 2'd1) begin
          n_head      = wr_entry;
          n_head_pend = wr_pend;
        end else begin
          n_head      = r_tail;
          n_head_pend = r_tail_pend;
          n_tail      = wr_entry;
          n_tail_pend = wr_pend;
        end
      end
      default: ;
    endcase
    if (chk_done) begin
      if (n_head_pend) begin
        n_head_pend = 1'b0;
        n_head.err  = chk_err;
      end
      if (n_tail_pend) begin
        n_tail_pend = 1'b0;
        n_tail.err  = chk_err;
      end
    end
  end

  always_ff @(posedge rclk or negedge reset_L) begin
    if (!reset_L) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_head_pend <= 1'b0;
      r_tail_pend <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_head      <= n_head;
      r_tail      <= n_tail;
      r_head_pend <= n_head_pend;
      r_tail_pend <= n_tail_pend;
      r_count     <= n_count;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// fifo_pkt_reader: parses length-prefixed packets from the async FIFO read port into a sop/eop stream (rev 1.0)
// Optional trailing XOR checksum word and out_err port when FIFO_PKT_READER_CHECKSUM_EN is defined.
module fifo_pkt_reader #(
  parameter int DWIDTH     = 8,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              rclk,
  input  logic              reset_L,
  input  logic              empty,
  input  logic [DWIDTH-1:0] rdata,
  output logic              pop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
`ifdef FIFO_PKT_READER_CHECKSUM_EN
  output logic              out_err,
`endif
  output logic              busy,
  output logic [15:0]       pkt_cnt
);
  import fifo_pkt_pkg::*;

  localparam logic [1:0] OBUF_FULL = 2'(OBUF_DEPTH);

  state_t            r_state;
  logic [DWIDTH-1:0] r_remaining;
  logic              r_first;
  logic [15:0]       r_pkt_cnt;

  obuf_entry_t w_wr_entry, w_head;
  logic [1:0]  w_count;
  logic        w_space, w_xfer, w_last, w_wr, w_pend, w_chk_done, w_chk_err;

  assign w_space = (w_count < OBUF_FULL) || (out_valid && out_ready);
  assign w_xfer  = pop;
  assign w_last  = (r_remaining == DWIDTH'(1));
  assign w_wr    = w_xfer && (r_state == ST_PAYLOAD);

  always_comb begin
    pop = 1'b0;
    case (r_state)
      ST_IDLE:    pop = !empty;
      ST_PAYLOAD: pop = !empty && w_space;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
      ST_CHK:     pop = !empty;
`endif
      default:    pop = 1'b0;
    endcase
  end

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.data = rdata;
    w_wr_entry.sop  = r_first;
    w_wr_entry.eop  = w_last;
  end

`ifdef FIFO_PKT_READER_CHECKSUM_EN
  logic [DWIDTH-1:0] r_xor;
  // The eop word waits in the buffer until the checksum word arrives.
  assign w_pend     = w_last;
  assign w_chk_done = w_xfer && (r_state == ST_CHK);
  assign w_chk_err  = (rdata != r_xor);
  assign out_err    = w_head.err;
`else
  logic unused_err;
  assign w_pend     = 1'b0;
  assign w_chk_done = 1'b0;
  assign w_chk_err  = 1'b0;
  assign unused_err = w_head.err;
`endif

  always_ff @(posedge rclk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_pkt_cnt   <= '0;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          if (rdata == '0) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
          end else begin
            r_remaining <= rdata;
            r_first     <= 1'b1;
            r_state     <= ST_PAYLOAD;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
            r_xor       <= '0;
`endif
          end
        end
        ST_PAYLOAD: begin
          r_remaining <= r_remaining - DWIDTH'(1);
          r_first     <= 1'b0;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
          r_xor       <= r_xor ^ rdata;
          if (w_last) r_state <= ST_CHK;
`else
          if (w_last) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
            r_state   <= ST_IDLE;
          end
`endif
        end
`ifdef FIFO_PKT_READER_CHECKSUM_EN
        ST_CHK: begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
          r_state   <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fifo_pkt_obuf u_obuf (
    .rclk     (rclk),
    .reset_L  (reset_L),
    .wr_en    (w_wr),
    .wr_entry (w_wr_entry),
    .wr_pend  (w_pend),
    .rd_ready (out_ready),
    .chk_done (w_chk_done),
    .chk_err  (w_chk_err),
    .valid    (out_valid),
    .head     (w_head),
    .count    (w_count)
  );

  assign out_data = w_head.data;
  assign out_sop  = w_head.sop;
  assign out_eop  = w_head.eop;
  assign busy     = (r_state == ST_PAYLOAD) || (w_count != 2'd0);
  assign pkt_cnt  = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_reader.sv
`default_nettype none
// tb_fifo_pkt_reader: directed packets against a queue-based stream model of fifo_pkt_reader (rev 1.0)
module tb_fifo_pkt_reader;

  logic        rclk = 1'b0;
  logic        reset_L = 1'b1;
  logic        empty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        out_ready = 1'b0;
  logic        pop, out_valid, out_sop, out_eop, busy;
  logic [7:0]  out_data;
  logic [15:0] pkt_cnt;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
  logic        out_err;
`endif

  fifo_pkt_reader #(.DWIDTH(8), .OBUF_DEPTH(2)) dut (
    .rclk      (rclk),
    .reset_L   (reset_L),
    .empty     (empty),
    .rdata     (rdata),
    .pop       (pop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
`ifdef FIFO_PKT_READER_CHECKSUM_EN
    .out_err   (out_err),
`endif
    .busy      (busy),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  int n_checks = 0;
  int n_pass = 0;

  // FIFO contents with a per-word kind: 0 header, 1 payload, 2 last payload, 3 checksum.
  logic [7:0] fifo_q[$];
  int         kind_q[$];
  bit         end_q[$];
  exp_t       exp_q[$];
  logic [7:0] pl[$];
  bit         empty_force = 1'b0;

  int  buffered = 0;
  bit  in_pkt = 1'b0;
  bit  pend = 1'b0;
  int  pkt_model = 0;
  int  xfer_total = 0;
  int  cyc = 0;
  bit  last_pop = 1'b0;
  int  xfer_cyc[$];
  int  acc_cyc[$];
  logic [7:0] acc_dat[$];
  bit  acc_sop[$];
  bit  acc_eop[$];
  bit  acc_err[$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endfunction

  function automatic void refresh();
    empty = empty_force || (fifo_q.size() == 0);
    rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endfunction

  function automatic void clear_model();
    fifo_q.delete(); kind_q.delete(); end_q.delete(); exp_q.delete();
    buffered = 0; in_pkt = 1'b0; pend = 1'b0; pkt_model = 0; empty_force = 1'b0;
  endfunction

  function automatic void push_word(input logic [7:0] v, input int k, input bit e);
    fifo_q.push_back(v); kind_q.push_back(k); end_q.push_back(e);
  endfunction

  // Packet from pl: header N, payload, then (checksum build) XOR word or the corrupt value.
  function automatic void push_pkt(input bit corrupt, input logic [7:0] bad);
    int n;
    logic [7:0] x;
    bit err, last_ends;
    exp_t e;
    n = pl.size();
    x = 8'h00;
    foreach (pl[i]) x ^= pl[i];
    err = corrupt && (bad != x);
`ifdef FIFO_PKT_READER_CHECKSUM_EN
    last_ends = 1'b0;
`else
    last_ends = 1'b1;
`endif
    push_word(8'(n), 0, n == 0);
    for (int i = 0; i < n; i++) begin
      push_word(pl[i], (i == n - 1) ? 2 : 1, (i == n - 1) && last_ends);
      e.d = pl[i]; e.sop = (i == 0); e.eop = (i == n - 1); e.err = (i == n - 1) && err;
      exp_q.push_back(e);
    end
`ifdef FIFO_PKT_READER_CHECKSUM_EN
    if (n > 0) push_word(corrupt ? bad : x, 3, 1'b1);
`endif
  endfunction

  task automatic sampler();
    bit s_xfer, s_acc;
    exp_t e;
    forever begin
      @(negedge rclk);
      #2 refresh();
      #2 cyc++;
      s_xfer = 1'b0;
      s_acc  = 1'b0;
      if (!reset_L) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sop_eop", {out_sop, out_eop}, 0);
      end else begin
        if (empty) check("pop_while_empty", pop, 0);
        check("pkt_cnt", pkt_cnt, 32'(pkt_model % 65536));
        check("busy", busy, in_pkt || (buffered > 0));
        check("out_valid", out_valid, (buffered > 0) && !(pend && buffered == 1));
        if (out_valid) begin
          check("word_available", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("out_data", out_data, e.d);
            check("out_sop", out_sop, e.sop);
            check("out_eop", out_eop, e.eop);
`ifdef FIFO_PKT_READER_CHECKSUM_EN
            check("out_err", out_err, e.err);
`endif
            if (out_ready) begin
              exp_q.delete(0);
              acc_cyc.push_back(cyc); acc_dat.push_back(out_data);
              acc_sop.push_back(out_sop); acc_eop.push_back(out_eop);
`ifdef FIFO_PKT_READER_CHECKSUM_EN
              acc_err.push_back(out_err);
`endif
              s_acc = 1'b1;
            end
          end
        end
        s_xfer   = pop && !empty;
        last_pop = pop;
        if (s_xfer) xfer_cyc.push_back(cyc);
      end
      @(posedge rclk);
      #1;
      if (s_xfer && fifo_q.size() != 0) begin
        if (kind_q[0] == 1 || kind_q[0] == 2) buffered++;
`ifdef FIFO_PKT_READER_CHECKSUM_EN
        if (kind_q[0] == 2) pend = 1'b1;
`endif
        if (kind_q[0] == 3) pend = 1'b0;
        in_pkt = !end_q[0];
        if (end_q[0]) pkt_model++;
        fifo_q.delete(0); kind_q.delete(0); end_q.delete(0);
        xfer_total++;
      end
      if (s_acc) buffered--;
      refresh();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    reset_L = 1'b0;
    clear_model();
    tick(3);
    reset_L = 1'b1;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int i = 0;
    while (xfer_total < target && i < budget) begin tick(1); i++; end
    check("wait_xfers", xfer_total >= target, 1);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && i < budget) begin tick(1); i++; end
    check("drain", exp_q.size() + fifo_q.size(), 0);
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, x0, x1;
    fork sampler(); join_none
    do_reset();
    out_ready = 1'b1;

    // Three-word packet streaming at full rate
    b = xfer_cyc.size(); a = acc_cyc.size();
    pl = '{8'hA1, 8'hA2, 8'hA3};
    push_pkt(1'b0, 8'h00);
    wait_drain(60);
    check("t1_pop_run", xfer_cyc[b+3] - xfer_cyc[b], 3);
    check("t1_first_latency", acc_cyc[a] - xfer_cyc[b+1], 1);
`ifndef FIFO_PKT_READER_CHECKSUM_EN
    check("t1_out_run", acc_cyc[a+2] - acc_cyc[a], 2);
`endif
    check("t1_words", {acc_dat[a], acc_dat[a+1], acc_dat[a+2]}, 24'hA1A2A3);
    check("t1_sop_eop", {acc_sop[a], acc_eop[a], acc_sop[a+1], acc_eop[a+1], acc_sop[a+2], acc_eop[a+2]}, 6'b100001);
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_busy", busy, 0);

    // Zero-length header, then a single-word packet
    do_reset();
    a = acc_cyc.size();
    pl = {};
    push_pkt(1'b0, 8'h00);
    pl = '{8'h55};
    push_pkt(1'b0, 8'h00);
    wait_drain(60);
    check("t2_words", acc_cyc.size() - a, 1);
    check("t2_data", acc_dat[a], 8'h55);
    check("t2_sop_eop", {acc_sop[a], acc_eop[a]}, 2'b11);
    check("t2_pkt_cnt", pkt_cnt, 2);

    // Backpressure: only two payload words may be popped
    out_ready = 1'b0;
    a = acc_cyc.size(); x0 = xfer_total;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_pkt(1'b0, 8'h00);
    tick(12);
    check("t3_pops", xfer_total - x0, 3);
    check("t3_pop_low", last_pop, 0);
    check("t3_valid", out_valid, 1);
    check("t3_head", out_data, 8'h01);
    out_ready = 1'b1;
    wait_drain(60);
    check("t3_words", {acc_dat[a], acc_dat[a+1], acc_dat[a+2], acc_dat[a+3]}, 32'h01020304);
    check("t3_pkt_cnt", pkt_cnt, 3);

    // FIFO runs dry for three cycles between payload words 2 and 3
    a = acc_cyc.size(); x0 = xfer_total;
    pl = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    push_pkt(1'b0, 8'h00);
    wait_xfers(x0 + 3, 30);
    empty_force = 1'b1;
    x1 = xfer_total;
    tick(3);
    check("t4_gap_pops", xfer_total - x1, 0);
    empty_force = 1'b0;
    wait_drain(60);
    check("t4_sops", {acc_sop[a], acc_sop[a+1], acc_sop[a+2], acc_sop[a+3], acc_sop[a+4]}, 5'b10000);
    check("t4_eops", {acc_eop[a], acc_eop[a+1], acc_eop[a+2], acc_eop[a+3], acc_eop[a+4]}, 5'b00001);
    check("t4_last", acc_dat[a+4], 8'h15);
    check("t4_pkt_cnt", pkt_cnt, 4);

    // Reset in the middle of a six-word packet
    out_ready = 1'b0;
    x0 = xfer_total;
    pl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    push_pkt(1'b0, 8'h00);
    wait_xfers(x0 + 3, 30);
    tick(2);
    check("t5_valid_before", out_valid, 1);
    reset_L = 1'b0;
    clear_model();
    #1 check("t5_valid_drop", out_valid, 0);
    tick(2);
    reset_L = 1'b1;
    tick(1);
    check("t5_pkt_cnt", pkt_cnt, 0);
    check("t5_busy", busy, 0);
    out_ready = 1'b1;
    a = acc_cyc.size();
    pl = '{8'h77};
    push_pkt(1'b0, 8'h00);
    wait_drain(60);
    check("t5_after_data", acc_dat[a], 8'h77);
    check("t5_after_sop_eop", {acc_sop[a], acc_eop[a]}, 2'b11);
    check("t5_after_pkt_cnt", pkt_cnt, 1);

`ifdef FIFO_PKT_READER_CHECKSUM_EN
    // Good checksum 0xFF, then the same payload with a corrupt 0xFE
    a = acc_cyc.size();
    pl = '{8'h0F, 8'hF0};
    push_pkt(1'b0, 8'h00);
    wait_drain(60);
    check("c1_eop_data", acc_dat[a+1], 8'hF0);
    check("c1_eop_err", {acc_eop[a+1], acc_err[a+1]}, 2'b10);
    push_pkt(1'b1, 8'hFE);
    wait_drain(60);
    check("c2_eop_err", {acc_eop[a+3], acc_err[a+3]}, 2'b11);
    check("c2_pkt_cnt", pkt_cnt, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
